pll_cfg_sequencer: RTL
======================

// Module: pll_cfg_sequencer
// PURPOSE
//  Runtime reprogramming of an altera_pll via its reconfig block. Takes a full counter set (N, M,
//  C0..C[NUM_CLOCKS-1]) and writes it over the Avalon-MM mgmt port. Sets mode, starts, then waits
//  for a stable lock. On lock timeout it pulses the PLL reset and retries, up to MAX_RETRY.
//  Sits between core video/CPU clock-mode logic and the PLL reconfig block; generalises fixed-frequency PLL wrappers.
// PARAMETERS
//  NUM_CLOCKS     2      outputs reprogrammed, 1..18; C counter index = output number
//  LOCK_TIMEOUT   65535  cycles after start write before lock is declared failed
//  SETTLE_CYCLES  16     consecutive cycles pll_locked must be high to count as locked
//  MAX_RETRY      3      retries after first attempt before error
//  RST_CYCLES     8      pll_rst pulse width on retry
// PORTS
//  clk              in   1              mgmt clock, same clock as reconfig block
//  rst_n            in   1              async assert, active-low reset
//  cfg_req          in   1              request; accepted when high and busy low
//  cfg_n            in   18             N counter word {odd,bypass,hi[7:0],lo[7:0]}
//  cfg_m            in   18             M counter word, same format
//  cfg_c            in   18*NUM_CLOCKS  C counter words, Ck at [18k+17:18k]
//  cfg_frac         in   32             M fractional value (PLL_CFG_FRAC_EN only)
//  busy             out  1              high from accept to done
//  done             out  1              1-cycle pulse at end of sequence (success or error)
//  error            out  1              sticky after final lock failure; cleared on next accept
//  mgmt_address     out  6              reconfig register address
//  mgmt_write       out  1              write strobe
//  mgmt_read        out  1              tied 0
//  mgmt_writedata   out  32             write data
//  mgmt_waitrequest in   1              stall; transfer completes when write=1 and waitrequest=0
//  pll_locked       in   1              PLL locked, async to clk; synchronised internally (2 flops)
//  pll_rst          out  1              PLL reset, active-high
// BEHAVIOUR
//  Reset: busy=done=error=mgmt_write=mgmt_read=pll_rst=0, mgmt_address=0, mgmt_writedata=0, FSM=IDLE, retry=0.
//  Accept: cfg_req & ~busy in IDLE registers all cfg_* inputs. busy rises next cycle.
//  cfg_req while busy is ignored, not queued. Inputs may change after accept.
//  FSM: IDLE -> WR_MODE(addr 0, data 0) -> WR_N(addr 3) -> WR_M(addr 4) -> [WR_FRAC] -> WR_C(addr 5, k=0..NUM_CLOCKS-1)
//    -> WR_START(addr 2, data 0) -> WAIT_LOCK -> IDLE; on timeout: PLL_RST -> WR_MODE.
//  N/M write data = {14'b0, word}. C data = {9'b0, k[4:0], word_k} (select at [22:18]).
//  Avalon rule: address/data/write held stable while waitrequest=1. Each state advances only on the
//    cycle write & ~waitrequest. Back-to-back writes with no idle cycle between.
//  Zero-waitrequest latency: accept -> start write completes in 4+NUM_CLOCKS cycles (+1 with FRAC).
//  WAIT_LOCK: timer from 0. Synced lock ignored for first 4 cycles (lock drop latency).
//    Stable lock = SETTLE_CYCLES consecutive high samples. A low sample resets the settle count.
//    Stable lock before timer=LOCK_TIMEOUT -> done pulse, busy low same cycle, error=0.
//    Timeout with retry<MAX_RETRY -> retry++, pll_rst high RST_CYCLES, then full rewrite from WR_MODE.
//    Timeout with retry=MAX_RETRY -> error=1, done pulse, IDLE.
//  Lock counted at exactly the SETTLE_CYCLES-th sample, even if timer expires that cycle (success wins).
//  Counters sized $clog2(param+1). No wrap: timer saturates.
//  Reset mid-sequence: outputs clear asynchronously and any write aborts. Reconfig state is undefined;
//    next accepted request rewrites every register.
// CONFIGURATION
//  PLL_CFG_FRAC_EN defined:
//    WR_FRAC state writes addr 7 with cfg_frac between WR_M and WR_C.
//  Not defined:
//    cfg_frac port absent, no addr-7 write. Fractional value left as last programmed.
// TESTING
//  1 NUM_CLOCKS=2, waitrequest=0, N=0x10000, M=0x00C0C, C0=0x01414, C1=0x00303, lock after 20 cycles ->
//    write sequence (0,0),(3,0x10000),(4,0x00C0C),(5,0x001414),(5,0x040303),(2,0); done at settle; error=0.
//  2 waitrequest held 3 cycles on each write -> address/data stable while stalled; same sequence, each
//    write takes 4 cycles.
//  3 pll_locked never high, LOCK_TIMEOUT=100, MAX_RETRY=1 -> pll_rst 8-cycle pulse, second full write
//    sequence, then error=1 and one done pulse.
//  4 Lock glitches low once at settle count 10 -> count restarts; done exactly 16 cycles after last rise.
//  5 cfg_req held during busy with new values -> ignored; only first set written; one done.
//  6 rst_n low mid WR_C -> mgmt_write=0 at once; after release, new request completes full sequence;
//    FRAC build adds (7,cfg_frac) after M.

Source files
------------

// File: rtl/pll_cfg_sequencer.sv
// Writes a full N/M/C counter set to an altera_pll reconfig block over Avalon-MM, then waits for stable lock.
// Define PLL_CFG_FRAC_EN to add the cfg_frac port and the fractional-M (addr 7) write.
module pll_cfg_sequencer #(
  parameter int NUM_CLOCKS    = 2,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 16,
  parameter int MAX_RETRY     = 3,
  parameter int RST_CYCLES    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_req,
  input  logic [17:0]              cfg_n,
  input  logic [17:0]              cfg_m,
  input  logic [18*NUM_CLOCKS-1:0] cfg_c,
`ifdef PLL_CFG_FRAC_EN
  input  logic [31:0]              cfg_frac,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [5:0]               mgmt_address,
  output logic                     mgmt_write,
  output logic                     mgmt_read,
  output logic [31:0]              mgmt_writedata,
  input  logic                     mgmt_waitrequest,
  input  logic                     pll_locked,
  output logic                     pll_rst
);

  localparam int TMR_W       = (LOCK_TIMEOUT  > 0) ? $clog2(LOCK_TIMEOUT + 1)  : 1;
  localparam int SET_W       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int RTY_W       = (MAX_RETRY     > 0) ? $clog2(MAX_RETRY + 1)     : 1;
  localparam int RST_W       = (RST_CYCLES    > 0) ? $clog2(RST_CYCLES + 1)    : 1;
  localparam int LOCK_IGNORE = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_MODE, S_WR_N, S_WR_M, S_WR_FRAC, S_WR_C, S_WR_START, S_WAIT_LOCK, S_PLL_RST
  } state_t;

  state_t               state_q, state_nxt;
  logic [4:0]           idx_q, idx_nxt;
  logic [RTY_W-1:0]     retry_q, retry_nxt;
  logic [TMR_W-1:0]     timer_q, timer_nxt;
  logic [SET_W-1:0]     settle_q, settle_nxt;
  logic [RST_W-1:0]     rcnt_q, rcnt_nxt;
  logic                 busy_nxt, done_nxt, error_nxt;
  logic                 accept, xfer, lock_cnt;
  logic                 lock_s1, lock_s2;
  logic [17:0]          cfg_n_q, cfg_m_q, c_word;
  logic [18*NUM_CLOCKS-1:0] cfg_c_q;
`ifdef PLL_CFG_FRAC_EN
  logic [31:0]          cfg_frac_q;
`endif

  assign mgmt_read = 1'b0;
  assign pll_rst   = (state_q == S_PLL_RST);
  assign xfer      = mgmt_write & ~mgmt_waitrequest;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      retry_q  <= '0;
      timer_q  <= '0;
      settle_q <= '0;
      rcnt_q   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      lock_s1  <= 1'b0;
      lock_s2  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      idx_q    <= idx_nxt;
      retry_q  <= retry_nxt;
      timer_q  <= timer_nxt;
      settle_q <= settle_nxt;
      rcnt_q   <= rcnt_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      error    <= error_nxt;
      lock_s1  <= pll_locked;
      lock_s2  <= lock_s1;
    end
  end

  // Request snapshot: data only, so no reset; the caller may change inputs once accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      cfg_n_q    <= cfg_n;
      cfg_m_q    <= cfg_m;
      cfg_c_q    <= cfg_c;
`ifdef PLL_CFG_FRAC_EN
      cfg_frac_q <= cfg_frac;
`endif
    end
  end

  always_comb begin
    c_word = '0;
    for (int k = 0; k < NUM_CLOCKS; k++)
      if (idx_q == 5'(k)) c_word = cfg_c_q[18*k +: 18];
  end

  always_comb begin
    state_nxt      = state_q;
    idx_nxt        = idx_q;
    retry_nxt      = retry_q;
    timer_nxt      = timer_q;
    settle_nxt     = settle_q;
    rcnt_nxt       = rcnt_q;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    error_nxt      = error;
    accept         = 1'b0;
    lock_cnt       = 1'b0;
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (cfg_req) begin
          accept    = 1'b1;
          busy_nxt  = 1'b1;
          error_nxt = 1'b0;
          retry_nxt = '0;
          idx_nxt   = '0;
          state_nxt = S_WR_MODE;
        end
      end
      S_WR_MODE: begin
        mgmt_write = 1'b1;
        if (xfer) state_nxt = S_WR_N;
      end
      S_WR_N: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd3;
        mgmt_writedata = {14'b0, cfg_n_q};
        if (xfer) state_nxt = S_WR_M;
      end
      S_WR_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd4;
        mgmt_writedata = {14'b0, cfg_m_q};
        if (xfer) begin
          idx_nxt = '0;
`ifdef PLL_CFG_FRAC_EN
          state_nxt = S_WR_FRAC;
`else
          state_nxt = S_WR_C;
`endif
        end
      end
`ifdef PLL_CFG_FRAC_EN
      S_WR_FRAC: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd7;
        mgmt_writedata = cfg_frac_q;
        if (xfer) state_nxt = S_WR_C;
      end
`endif
      S_WR_C: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd5;
        mgmt_writedata = {9'b0, idx_q, c_word};
        if (xfer) begin
          if (idx_q == 5'(NUM_CLOCKS - 1)) state_nxt = S_WR_START;
          else idx_nxt = idx_q + 5'd1;
        end
      end
      S_WR_START: begin
        mgmt_write   = 1'b1;
        mgmt_address = 6'd2;
        if (xfer) begin
          timer_nxt  = '0;
          settle_nxt = '0;
          state_nxt  = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        // Synced lock is stale for the first few cycles after start; success wins over a same-cycle timeout.
        lock_cnt = lock_s2 && (int'(timer_q) >= LOCK_IGNORE);
        if (lock_cnt && settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          error_nxt = 1'b0;
          state_nxt = S_IDLE;
        end else if (timer_q == TMR_W'(LOCK_TIMEOUT)) begin
          if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_nxt = retry_q + 1'b1;
            rcnt_nxt  = '0;
            state_nxt = S_PLL_RST;
          end else begin
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            error_nxt = 1'b1;
            state_nxt = S_IDLE;
          end
        end else begin
          timer_nxt  = timer_q + 1'b1;
          settle_nxt = lock_cnt ? settle_q + 1'b1 : '0;
        end
      end
      S_PLL_RST: begin
        if (rcnt_q == RST_W'(RST_CYCLES - 1)) state_nxt = S_WR_MODE;
        else rcnt_nxt = rcnt_q + 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
